snes_ctrl_reader: RTL and testbench
===================================

# snes_ctrl_reader

Polls a SNES-style serial game controller and presents its button state as a parallel, active-high word to the game-logic input path. The block generates the controller's latch and serial-clock strobes and synchronizes the returned data line. It shifts NUM_BITS samples into a shift register and publishes a registered button word with a one-cycle valid strobe once per poll period.

## Interface
- NUM_BITS, 16, serial bits read per poll (SNES = 16; bits 12–15 read 1 on a standard pad)
- HALF_CYCLES, 300, clk cycles per half serial-clock period (6 µs at 50 MHz); minimum 2
- POLL_CYCLES, 833_333, clk cycles from one latch rising edge to the next (~60 Hz); must be ≥ 2·HALF_CYCLES·(NUM_BITS+1)+4
- clk  in  1  system clock
- rst_l  in  1  asynchronous, active-low reset
- poll_en  in  1  enables polling; when low the block finishes its current read, then parks in IDLE
- ctrl_data  in  1  serial data from the controller, active-low, asynchronous to clk
- ctrl_latch  out  1  latch strobe to the controller, active-high
- ctrl_clk  out  1  serial clock to the controller, idles high
- buttons  out  NUM_BITS  button state, 1 = pressed, bit i = i-th serial bit
- buttons_valid  out  1  one-cycle pulse when buttons is updated

## Operation
- ctrl_data passes through a 2-flop synchronizer (both flops reset to 1); all sampling uses the synchronized value.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE, WAIT.
- IDLE: ctrl_latch=0, ctrl_clk=1; go to LATCH when poll_en=1.
- LATCH: ctrl_latch=1 for 2·HALF_CYCLES cycles, then LOW with bit index 0.
- LOW: ctrl_clk=0 for HALF_CYCLES cycles; on the last cycle, shift in ~ctrl_data_sync and go to HIGH.
- HIGH: ctrl_clk=1 for HALF_CYCLES cycles. If bit index == NUM_BITS-1, go to DONE; otherwise increment the index and go to LOW.
- Bit order: bit 0 is the first sample after the latch falls and lands in buttons[0]. Shift right, new sample enters at the MSB.
- DONE (1 cycle): load buttons from the shift register, pulse buttons_valid, then go to WAIT.
- WAIT: count until POLL_CYCLES have elapsed since LATCH entry. Then go to LATCH if poll_en=1, otherwise IDLE.
- poll_en falling mid-read has no effect until DONE completes. poll_en toggling in WAIT is only evaluated at WAIT expiry.
- Cycle counter width: $clog2(POLL_CYCLES+1). Bit index width: $clog2(NUM_BITS). No wrap occurs inside a read.

## Timing
- Reset values: ctrl_latch=0, ctrl_clk=1, buttons=0, buttons_valid=0, FSM=IDLE, shift register=0.
- Reset mid-read returns to IDLE immediately and discards the partial word. buttons stays at 0 until the first complete read.
- Latency from poll_en rising in IDLE to latch high is 1 cycle (latch is registered).
- Read duration: 2·HALF_CYCLES + 2·HALF_CYCLES·NUM_BITS cycles, then 1 DONE cycle.
- buttons_valid asserts the cycle after the final HIGH phase ends.
- buttons is stable between pulses.
- All outputs are registered, glitch-free.

## Configuration
- CTRL_DEBOUNCE_EN defined: a completed word is published only when it equals the previous completed word (compare register, reset 0).
  - Mismatch: buttons is unchanged and buttons_valid is not pulsed; the compare register is still updated.
- CTRL_DEBOUNCE_EN undefined: every completed word is published and pulsed.

## Structure
- Package snes_ctrl_pkg holds:
  - the FSM state enum
  - button index constants: BTN_B=0, BTN_Y=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DOWN=5, BTN_LEFT=6, BTN_RIGHT=7, BTN_A=8, BTN_X=9, BTN_L=10, BTN_R=11
- Bit capture reuses the library sipo (WIDTH=NUM_BITS, right shift, reset input tied to the LATCH-entry strobe).
- The bit index reuses the library counter.
- One new sub-module: snes_ctrl_sync (2-flop synchronizer, reset to 1).

## Test plan
Bench uses NUM_BITS=16, HALF_CYCLES=4, POLL_CYCLES=200, and a behavioural controller model returning pattern P.
- Reset, poll_en=1, P=16'hFFFE (only B pressed, active-low) -> latch high for 8 cycles; 16 clk low pulses of 4 cycles each; buttons=16'h0001 with a one-cycle valid.
- P=16'h0FFF sent on successive polls -> buttons=16'hF000; latch rising edges exactly 200 cycles apart.
- poll_en dropped during bit 5 -> read completes and valid pulses once; FSM parks in IDLE with ctrl_clk=1 and ctrl_latch=0.
- rst_l asserted during bit 9 -> ctrl_clk=1, ctrl_latch=0, buttons=0 immediately. After release, the next full read publishes the correct word.
- Undefined vs defined CTRL_DEBOUNCE_EN, P alternating 16'hFF7F / 16'hFFFF -> undefined: valid every poll, buttons toggling 16'h0080/16'h0000. Defined: no valid after the first poll, buttons stays 0.
- ctrl_data glitch of 1 cycle outside any LOW-phase sample cycle -> buttons unaffected.

Source files
------------

// File: rtl/snes_ctrl_pkg.sv
// Shared types and constants for the SNES controller reader.
package snes_ctrl_pkg;

    // Reader FSM states
    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StLow,
        StHigh,
        StDone,
        StWait
    } snes_state_e;

    // Button positions within the published word (bit i = i-th serial bit)
    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;

endpackage

// File: rtl/counter.sv
// Library up-counter with synchronous clear and count enable.
module counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] cnt_d, cnt_q;

    // Clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/sipo.sv
// Library serial-in parallel-out shift register; right shift, new bit enters at the MSB.
module sipo #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] shift_d, shift_q;

    // Next shift value; clear wins over shift
    always_comb begin
        shift_d = shift_q;
        if (clr_i) begin
            shift_d = '0;
        end else if (en_i) begin
            shift_d = {d_i, shift_q[WIDTH-1:1]};
        end
    end

    // Shift register state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q_o = shift_q;

endmodule

// File: rtl/snes_ctrl_sync.sv
// Two-flop synchronizer for the controller data line; resets to the idle (high) level.
module snes_ctrl_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, sync_q;

    // Two-stage resynchronization into the clk domain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/snes_ctrl_reader.sv
// SNES serial controller poller: drives latch/clock strobes, captures NUM_BITS samples
// and publishes an active-high button word with a one-cycle valid pulse per poll.
// Optional: define CTRL_DEBOUNCE_EN to publish a word only when it repeats the previous one.
module snes_ctrl_reader
    import snes_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BITS    = 16,
    parameter int unsigned HALF_CYCLES = 300,
    parameter int unsigned POLL_CYCLES = 833_333
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                poll_en,
    input  logic                ctrl_data,
    output logic                ctrl_latch,
    output logic                ctrl_clk,
    output logic [NUM_BITS-1:0] buttons,
    output logic                buttons_valid
);

    localparam int unsigned CntW = $clog2(POLL_CYCLES + 1);
    localparam int unsigned IdxW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int unsigned PhW  = $clog2(2 * HALF_CYCLES);

    localparam logic [PhW-1:0]  LatchLast = PhW'(2 * HALF_CYCLES - 1);
    localparam logic [PhW-1:0]  HalfLast  = PhW'(HALF_CYCLES - 1);
    localparam logic [CntW-1:0] PollLast  = CntW'(POLL_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_BITS - 1);

    snes_state_e         state_q;
    logic [PhW-1:0]      phase_q;
    logic [CntW-1:0]     poll_q;
    logic                latch_q;
    logic                clk_q;
    logic [NUM_BITS-1:0] buttons_q;
    logic                valid_q;
`ifdef CTRL_DEBOUNCE_EN
    logic [NUM_BITS-1:0] prev_q;
`endif

    logic                data_sync;
    logic [NUM_BITS-1:0] shift_word;
    logic [IdxW-1:0]     bit_idx;
    logic                phase_last;
    logic                poll_last;
    logic                idx_last;
    logic                latch_entry;
    logic                shift_en;
    logic                idx_inc;

    snes_ctrl_sync u_sync (
        .clk_i  (clk),
        .rst_ni (rst_l),
        .d_i    (ctrl_data),
        .q_o    (data_sync)
    );

    // Controller data is active-low; store pressed as 1
    sipo #(
        .WIDTH (NUM_BITS)
    ) u_sipo (
        .clk_i  (clk),
        .rst_ni (rst_l),
        .clr_i  (latch_entry),
        .en_i   (shift_en),
        .d_i    (~data_sync),
        .q_o    (shift_word)
    );

    counter #(
        .WIDTH (IdxW)
    ) u_bit_idx (
        .clk_i  (clk),
        .rst_ni (rst_l),
        .clr_i  (latch_entry),
        .en_i   (idx_inc),
        .q_o    (bit_idx)
    );

    // Phase/poll expiry decode and the strobes feeding the capture datapath
    always_comb begin
        phase_last = 1'b0;
        unique case (state_q)
            StLatch:      phase_last = (phase_q == LatchLast);
            StLow, StHigh: phase_last = (phase_q == HalfLast);
            default:      phase_last = 1'b0;
        endcase
        poll_last   = (poll_q == PollLast);
        idx_last    = (bit_idx == IdxLast);
        latch_entry = poll_en && ((state_q == StIdle) || ((state_q == StWait) && poll_last));
        shift_en    = (state_q == StLow) && phase_last;
        idx_inc     = (state_q == StHigh) && phase_last && !idx_last;
    end

    // Poll FSM with registered strobes and published word
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            poll_q    <= '0;
            latch_q   <= 1'b0;
            clk_q     <= 1'b1;
            buttons_q <= '0;
            valid_q   <= 1'b0;
`ifdef CTRL_DEBOUNCE_EN
            prev_q    <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            phase_q <= phase_q + PhW'(1);
            poll_q  <= poll_q + CntW'(1);
            unique case (state_q)
                StIdle: begin
                    phase_q <= '0;
                    poll_q  <= '0;
                    if (poll_en) begin
                        state_q <= StLatch;
                        latch_q <= 1'b1;
                    end
                end
                StLatch: begin
                    if (phase_last) begin
                        phase_q <= '0;
                        state_q <= StLow;
                        latch_q <= 1'b0;
                        clk_q   <= 1'b0;
                    end
                end
                StLow: begin
                    if (phase_last) begin
                        phase_q <= '0;
                        state_q <= StHigh;
                        clk_q   <= 1'b1;
                    end
                end
                StHigh: begin
                    if (phase_last) begin
                        phase_q <= '0;
                        if (idx_last) begin
                            // Word is complete (last shift happened at the end of LOW);
                            // publish so it is visible during the DONE cycle.
                            state_q <= StDone;
`ifdef CTRL_DEBOUNCE_EN
                            if (shift_word == prev_q) begin
                                buttons_q <= shift_word;
                                valid_q   <= 1'b1;
                            end
                            prev_q <= shift_word;
`else
                            buttons_q <= shift_word;
                            valid_q   <= 1'b1;
`endif
                        end else begin
                            state_q <= StLow;
                            clk_q   <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    state_q <= StWait;
                end
                StWait: begin
                    phase_q <= '0;
                    if (poll_last) begin
                        poll_q <= '0;
                        if (poll_en) begin
                            state_q <= StLatch;
                            latch_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    latch_q <= 1'b0;
                    clk_q   <= 1'b1;
                end
            endcase
        end
    end

    assign ctrl_latch    = latch_q;
    assign ctrl_clk      = clk_q;
    assign buttons       = buttons_q;
    assign buttons_valid = valid_q;

endmodule

// File: tb/tb_snes_ctrl_reader.sv
// Directed bench for snes_ctrl_reader with a behavioural SNES pad model.
module tb_snes_ctrl_reader;

    localparam int unsigned NB = 16;
    localparam int unsigned HC = 4;
    localparam int unsigned PC = 200;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          poll_en = 1'b0;
    logic          ctrl_data;
    logic          ctrl_latch;
    logic          ctrl_clk;
    logic [NB-1:0] buttons;
    logic          buttons_valid;

    logic [15:0] pat = 16'hFFFF;
    logic [15:0] pad_sh = 16'hFFFF;
    logic        pad_clk_prev = 1'b1;
    logic        glitch = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [15:0] prev_word = 16'h0000;
    logic [15:0] pub_word = 16'h0000;

    snes_ctrl_reader #(
        .NUM_BITS    (NB),
        .HALF_CYCLES (HC),
        .POLL_CYCLES (PC)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .poll_en       (poll_en),
        .ctrl_data     (ctrl_data),
        .ctrl_latch    (ctrl_latch),
        .ctrl_clk      (ctrl_clk),
        .buttons       (buttons),
        .buttons_valid (buttons_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pad model: latch loads the pattern, each ctrl_clk rising edge shifts to the next bit
    always @(posedge clk) begin
        if (ctrl_latch) pad_sh <= pat;
        else if (ctrl_clk && !pad_clk_prev) pad_sh <= {1'b1, pad_sh[15:1]};
        pad_clk_prev <= ctrl_clk;
    end

    assign ctrl_data = pad_sh[0] ^ glitch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected publish behaviour for one completed word
    task automatic expect_word(input logic [15:0] w, output logic ev, output logic [15:0] eb);
`ifdef CTRL_DEBOUNCE_EN
        ev = (w == prev_word);
        if (ev) pub_word = w;
        prev_word = w;
`else
        ev = 1'b1;
        pub_word = w;
`endif
        eb = pub_word;
    endtask

    // Wait (bounded) for a latch rising edge; returns the cycle stamp
    task automatic wait_rise(input string tag, output int t);
        logic prev;
        logic found;
        found = 1'b0;
        t = -1;
        prev = ctrl_latch;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (ctrl_latch && !prev) begin
                found = 1'b1;
                t = cyc;
            end
            prev = ctrl_latch;
        end
        chk({tag, "_rise"}, {31'd0, found}, 32'd1);
    endtask

    // Called at read cycle 0 (first latch-high cycle); checks the whole read
    task automatic read_check(input string tag, input logic [15:0] p, input int drop_at,
                              input int glitch_at);
        int lat_n;
        int low_n;
        int fall_n;
        int val_n;
        logic prev_c;
        logic ev;
        logic [15:0] eb;
        lat_n = 1;
        low_n = 0;
        fall_n = 0;
        val_n = 0;
        expect_word(~p, ev, eb);
        prev_c = ctrl_clk;
        for (int c = 1; c <= 136; c++) begin
            @(negedge clk);
            glitch = 1'b0;
            if (c == drop_at) poll_en = 1'b0;
            if (c == glitch_at) glitch = 1'b1;
            if (c < 136) begin
                lat_n += int'(ctrl_latch);
                low_n += int'(!ctrl_clk);
                if (prev_c && !ctrl_clk) fall_n++;
                val_n += int'(buttons_valid);
                prev_c = ctrl_clk;
            end
        end
        chk({tag, "_valid"}, {31'd0, buttons_valid}, {31'd0, ev});
        chk({tag, "_buttons"}, {16'd0, buttons}, {16'd0, eb});
        chk({tag, "_clk_idle"}, {31'd0, ctrl_clk}, 32'd1);
        chk({tag, "_latch_cycles"}, lat_n, 8);
        chk({tag, "_clk_low_cycles"}, low_n, 64);
        chk({tag, "_clk_pulses"}, fall_n, 16);
        chk({tag, "_early_valid"}, val_n, 0);
        @(negedge clk);
        glitch = 1'b0;
        chk({tag, "_valid_off"}, {31'd0, buttons_valid}, 32'd0);
        chk({tag, "_buttons_hold"}, {16'd0, buttons}, {16'd0, eb});
    endtask

    initial begin
        int t0;
        int t1;
        int t2;
        int t3;
        int lat_seen;
        int val_seen;
        logic lprev;

        // Reset state
        pat = 16'hFFFE;
        repeat (3) @(negedge clk);
        chk("rst_latch", {31'd0, ctrl_latch}, 32'd0);
        chk("rst_clk", {31'd0, ctrl_clk}, 32'd1);
        chk("rst_buttons", {16'd0, buttons}, 32'd0);
        chk("rst_valid", {31'd0, buttons_valid}, 32'd0);
        rst_l = 1'b1;
        @(negedge clk);
        chk("idle_latch", {31'd0, ctrl_latch}, 32'd0);

        // Only B pressed; latch one cycle after poll_en
        poll_en = 1'b1;
        @(negedge clk);
        chk("latch_latency", {31'd0, ctrl_latch}, 32'd1);
        t0 = cyc;
        read_check("p_fffe", 16'hFFFE, -1, -1);

        // Upper four bits pressed, two successive polls, fixed period
        pat = 16'h0FFF;
        wait_rise("p_0fff_a", t1);
        chk("period_1", t1 - t0, PC);
        read_check("p_0fff_a", 16'h0FFF, -1, -1);
        wait_rise("p_0fff_b", t2);
        chk("period_2", t2 - t1, PC);
        read_check("p_0fff_b", 16'h0FFF, -1, -1);

        // poll_en dropped during bit 5: read still completes
        pat = 16'hFFDF;
        wait_rise("drop", t3);
        chk("period_3", t3 - t2, PC);
        read_check("drop", 16'hFFDF, 50, -1);

        // Parks in IDLE after the poll period expires
        lat_seen = 0;
        val_seen = 0;
        lprev = ctrl_latch;
        repeat (300) begin
            @(negedge clk);
            if (ctrl_latch && !lprev) lat_seen++;
            val_seen += int'(buttons_valid);
            lprev = ctrl_latch;
        end
        chk("park_latch_rises", lat_seen, 0);
        chk("park_valid", val_seen, 0);
        chk("park_latch", {31'd0, ctrl_latch}, 32'd0);
        chk("park_clk", {31'd0, ctrl_clk}, 32'd1);

        // Reset during bit 9
        pat = 16'hFDFF;
        poll_en = 1'b1;
        @(negedge clk);
        chk("latch_latency_2", {31'd0, ctrl_latch}, 32'd1);
        repeat (82) @(negedge clk);
        chk("bit9_clk_low", {31'd0, ctrl_clk}, 32'd0);
        rst_l = 1'b0;
        #1;
        chk("midrst_clk", {31'd0, ctrl_clk}, 32'd1);
        chk("midrst_latch", {31'd0, ctrl_latch}, 32'd0);
        chk("midrst_buttons", {16'd0, buttons}, 32'd0);
        chk("midrst_valid", {31'd0, buttons_valid}, 32'd0);
        prev_word = 16'h0000;
        pub_word = 16'h0000;
        @(negedge clk);
        rst_l = 1'b1;
        wait_rise("after_rst", t0);
        read_check("after_rst", 16'hFDFF, -1, -1);

        // Alternating words: every poll publishes unless debounce is enabled
        for (int k = 0; k < 4; k++) begin
            pat = (k % 2 == 0) ? 16'hFF7F : 16'hFFFF;
            wait_rise("alt", t1);
            read_check("alt", pat, -1, -1);
        end

        // One-cycle data glitch during a HIGH phase does not reach the word
        pat = 16'hFFFB;
        wait_rise("glitch", t2);
        read_check("glitch", 16'hFFFB, -1, 37);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
